// File: rtl/svm_pkg.sv
// Shared types and helpers for the SVM PWM capture block: default width,
// capture FSM states and the saturating increment used by every counter.
package svm_pkg;

  localparam int D_WIDTH_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } capture_state_t;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/svm_high_counter.sv
// One saturating cycle counter with clear/load/increment control; used for
// the three phase high-time counts and the period length count.
module svm_high_counter
  import svm_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;

  // Load starts a new period with the current cycle already counted.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = {{(W-1){1'b0}}, bit_in};
    end else if (en && bit_in) begin
      cnt_d = W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/svm_pwm_capture.sv
// Per-period capture of the three SVM PWM phases: high-time counts, period
// length, lock and sticky timeout. SVM_CAPTURE_SYNC_EN adds 2-flop input sync.
module svm_pwm_capture
  import svm_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEFAULT,
  parameter int SLACK   = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               pwmA,
  input  logic               pwmB,
  input  logic               pwmC,
  input  logic               periodSync,
  input  logic [D_WIDTH-1:0] periodTop,
  input  logic               errClr,
  output logic [D_WIDTH:0]   dutyA,
  output logic [D_WIDTH:0]   dutyB,
  output logic [D_WIDTH:0]   dutyC,
  output logic [D_WIDTH:0]   periodMeas,
  output logic               dutyValid,
  output logic               locked,
  output logic               timeoutErr
);

  localparam int CW = D_WIDTH + 1;
  localparam int TW = D_WIDTH + 2;

  logic pwm_a_s, pwm_b_s, pwm_c_s, sync_s;

`ifdef SVM_CAPTURE_SYNC_EN
  logic [3:0] meta_q, meta_d, stab_q, stab_d;

  always_comb begin
    meta_d = {periodSync, pwmC, pwmB, pwmA};
    stab_d = meta_q;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      meta_q <= '0;
      stab_q <= '0;
    end else begin
      meta_q <= meta_d;
      stab_q <= stab_d;
    end
  end

  assign {sync_s, pwm_c_s, pwm_b_s, pwm_a_s} = stab_q;
`else
  assign {sync_s, pwm_c_s, pwm_b_s, pwm_a_s} = {periodSync, pwmC, pwmB, pwmA};
`endif

  capture_state_t state_q, state_d;
  logic           sync_q, sync_d;
  logic           valid_q, valid_d;
  logic           locked_q, locked_d;
  logic           err_q, err_d;
  logic [CW-1:0]  duty_a_q, duty_a_d;
  logic [CW-1:0]  duty_b_q, duty_b_d;
  logic [CW-1:0]  duty_c_q, duty_c_d;
  logic [CW-1:0]  period_q, period_d;

  logic [CW-1:0]  cnt_a, cnt_b, cnt_c, cnt_p;
  logic [TW-1:0]  thresh;
  logic           sync_edge, timeout;
  logic           cnt_clr, cnt_load, cnt_en;

  // Threshold is one bit wider than the counters so 2*periodTop+SLACK never wraps.
  assign thresh = (TW'(periodTop) << 1) + TW'(SLACK);

  always_comb begin
    sync_d    = sync_s;
    sync_edge = sync_s & ~sync_q;
    timeout   = (state_q == MEAS) && !sync_edge && ({1'b0, cnt_p} >= thresh);

    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    valid_d  = 1'b0;
    duty_a_d = duty_a_q;
    duty_b_d = duty_b_q;
    duty_c_d = duty_c_q;
    period_d = period_q;

    case (state_q)
      IDLE: begin
        if (sync_edge) begin
          state_d  = MEAS;
          cnt_load = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      MEAS: begin
        if (sync_edge) begin
          duty_a_d = cnt_a;
          duty_b_d = cnt_b;
          duty_c_d = cnt_c;
          period_d = cnt_p;
          valid_d  = 1'b1;
          cnt_load = 1'b1;
        end else if (timeout) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase

    // A timeout in the same cycle as errClr keeps the flag set.
    if (timeout) begin
      err_d = 1'b1;
    end else if (errClr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    locked_d = (state_d == MEAS);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      sync_q   <= 1'b0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      duty_a_q <= '0;
      duty_b_q <= '0;
      duty_c_q <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      duty_a_q <= duty_a_d;
      duty_b_q <= duty_b_d;
      duty_c_q <= duty_c_d;
      period_q <= period_d;
    end
  end

  svm_high_counter #(.W(CW)) u_cnt_a (
    .clk(clk), .rstb(rstb), .clr(cnt_clr), .load(cnt_load), .en(cnt_en),
    .bit_in(pwm_a_s), .cnt_o(cnt_a)
  );

  svm_high_counter #(.W(CW)) u_cnt_b (
    .clk(clk), .rstb(rstb), .clr(cnt_clr), .load(cnt_load), .en(cnt_en),
    .bit_in(pwm_b_s), .cnt_o(cnt_b)
  );

  svm_high_counter #(.W(CW)) u_cnt_c (
    .clk(clk), .rstb(rstb), .clr(cnt_clr), .load(cnt_load), .en(cnt_en),
    .bit_in(pwm_c_s), .cnt_o(cnt_c)
  );

  svm_high_counter #(.W(CW)) u_cnt_p (
    .clk(clk), .rstb(rstb), .clr(cnt_clr), .load(cnt_load), .en(cnt_en),
    .bit_in(1'b1), .cnt_o(cnt_p)
  );

  assign dutyA      = duty_a_q;
  assign dutyB      = duty_b_q;
  assign dutyC      = duty_c_q;
  assign periodMeas = period_q;
  assign dutyValid  = valid_q;
  assign locked     = locked_q;
  assign timeoutErr = err_q;

endmodule

// File: tb/tb_svm_pwm_capture.sv
// Randomized self-checking bench for svm_pwm_capture against a per-period
// summation model of the capture rules (default build, direct inputs).
module tb_svm_pwm_capture;

  localparam int DW    = 16;
  localparam int SLACK = 4;
  localparam int CMAX  = (1 << (DW + 1)) - 1;

  logic          clk = 1'b0;
  logic          rstb;
  logic          pwmA, pwmB, pwmC, periodSync, errClr;
  logic [DW-1:0] periodTop;
  logic [DW:0]   dutyA, dutyB, dutyC, periodMeas;
  logic          dutyValid, locked, timeoutErr;

  svm_pwm_capture #(.D_WIDTH(DW), .SLACK(SLACK)) dut (
    .clk(clk), .rstb(rstb),
    .pwmA(pwmA), .pwmB(pwmB), .pwmC(pwmC),
    .periodSync(periodSync), .periodTop(periodTop), .errClr(errClr),
    .dutyA(dutyA), .dutyB(dutyB), .dutyC(dutyC), .periodMeas(periodMeas),
    .dutyValid(dutyValid), .locked(locked), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: running sums since the last accepted sync edge.
  int  top;
  bit  rst_drv;
  bit  m_meas, m_prev;
  int  m_a, m_b, m_c, m_p;
  int  e_a, e_b, e_c, e_p;
  bit  e_v, e_l, e_e;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function void model_reset();
    m_meas = 0; m_prev = 0;
    m_a = 0; m_b = 0; m_c = 0; m_p = 0;
    e_a = 0; e_b = 0; e_c = 0; e_p = 0;
    e_v = 0; e_l = 0; e_e = 0;
  endfunction

  function void model_step(input bit a, input bit b, input bit c, input bit s, input bit clr);
    bit rise;
    bit to;
    int thr;
    rise   = s && !m_prev;
    m_prev = s;
    thr    = 2 * top + SLACK;
    to     = 0;
    e_v    = 0;
    if (rise) begin
      if (m_meas) begin
        e_a = m_a; e_b = m_b; e_c = m_c; e_p = m_p;
        e_v = 1;
      end
      m_meas = 1;
      m_p = 1; m_a = int'(a); m_b = int'(b); m_c = int'(c);
    end else if (m_meas) begin
      if (m_p >= thr) begin
        to = 1;
        m_meas = 0;
        m_p = 0; m_a = 0; m_b = 0; m_c = 0;
      end else begin
        m_p = sat(m_p + 1);
        m_a = sat(m_a + int'(a));
        m_b = sat(m_b + int'(b));
        m_c = sat(m_c + int'(c));
      end
    end
    if (to) e_e = 1;
    else if (clr) e_e = 0;
    e_l = m_meas;
  endfunction

  int          seen_valid;
  logic [DW:0] seen_a, seen_b, seen_c, seen_p;

  task automatic check_outputs();
    check_val("dutyA", 32'(dutyA), e_a);
    check_val("dutyB", 32'(dutyB), e_b);
    check_val("dutyC", 32'(dutyC), e_c);
    check_val("periodMeas", 32'(periodMeas), e_p);
    check_val("dutyValid", 32'(dutyValid), 32'(e_v));
    check_val("locked", 32'(locked), 32'(e_l));
    check_val("timeoutErr", 32'(timeoutErr), 32'(e_e));
  endtask

  task automatic drive_cycle(input bit a, input bit b, input bit c, input bit s, input bit clr);
    @(negedge clk);
    rstb = rst_drv; pwmA = a; pwmB = b; pwmC = c; periodSync = s; errClr = clr;
    periodTop = DW'(top);
    if (!rst_drv) model_reset();
    else model_step(a, b, c, s, clr);
    @(posedge clk);
    #1;
    check_outputs();
    if (dutyValid === 1'b1) begin
      seen_valid++;
      seen_a = dutyA; seen_b = dutyB; seen_c = dutyC; seen_p = periodMeas;
    end
  endtask

  // One period: sync high for sw cycles at its start, pwm windows or random bits.
  task automatic run_period(input int len, input int na, input int nb, input int nc,
                            input bit rnd, input int sw, input bit clr_rnd);
    int oa, ob, oc;
    oa = (na >= len) ? 0 : int'($urandom_range(len - na, 0));
    ob = (nb >= len) ? 0 : int'($urandom_range(len - nb, 0));
    oc = (nc >= len) ? 0 : int'($urandom_range(len - nc, 0));
    for (int i = 0; i < len; i++) begin
      bit a, b, c, clr;
      if (rnd) begin
        a = bit'($urandom); b = bit'($urandom); c = bit'($urandom);
      end else begin
        a = (i >= oa) && (i < oa + na);
        b = (i >= ob) && (i < ob + nb);
        c = (i >= oc) && (i < oc + nc);
      end
      clr = clr_rnd && ($urandom_range(49, 0) == 0);
      drive_cycle(a, b, c, (i < sw), clr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed %0t expected below 2000000", $time);
    $fatal(1);
  end

  initial begin
    int v0, to_k, len, sw;
    rstb = 1'b0; rst_drv = 1'b0;
    pwmA = 0; pwmB = 0; pwmC = 0; periodSync = 0; errClr = 0;
    top = 2048; periodTop = DW'(top);
    seen_valid = 0; seen_a = '0; seen_b = '0; seen_c = '0; seen_p = '0;
    model_reset();

    // Reset
    repeat (3) drive_cycle(1, 1, 1, 1, 0);
    check_val("rst_dutyA", 32'(dutyA), 0);
    check_val("rst_period", 32'(periodMeas), 0);
    check_val("rst_locked", 32'(locked), 0);
    rst_drv = 1'b1;

    // Partial period before first edge
    for (int i = 0; i < 700; i++)
      drive_cycle(bit'($urandom), bit'($urandom), bit'($urandom), 0, 0);
    check_val("no_valid_partial", seen_valid, 0);

    // Duty readback
    repeat (3) run_period(4096, 2048, 1024, 0, 0, 1, 0);
    check_val("valid_count", seen_valid, 2);
    check_val("first_pm", 32'(seen_p), 4096);
    check_val("dutyA_2048", 32'(seen_a), 2048);
    check_val("dutyB_1024", 32'(seen_b), 1024);
    check_val("dutyC_0", 32'(seen_c), 0);

    // Full duty, then a period ending exactly at the threshold
    run_period(4096, 4096, 0, 0, 0, 3, 0);
    run_period(4100, 0, 0, 0, 1, 1, 0);
    check_val("full_dutyA", 32'(seen_a), 4096);
    check_val("full_eq_pm", 32'(seen_a), 32'(seen_p));

    // Sync loss
    drive_cycle(0, 1, 0, 1, 0);
    check_val("boundary_pm", 32'(seen_p), 4100);
    check_val("boundary_err", 32'(timeoutErr), 0);
    to_k = 0;
    for (int k = 1; k <= 5000 && to_k == 0; k++) begin
      drive_cycle(bit'($urandom), bit'($urandom), bit'($urandom), 0, 0);
      if (timeoutErr === 1'b1) to_k = k;
    end
    check_val("timeout_cycle", to_k, 4100);
    check_val("locked_after_to", 32'(locked), 0);
    check_val("pm_kept", 32'(periodMeas), 4100);
    repeat (5) drive_cycle(0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 1);
    check_val("err_cleared", 32'(timeoutErr), 0);

    // errClr held through a timeout: set wins on that cycle
    top = 100;
    drive_cycle(1, 0, 1, 1, 0);
    for (int i = 0; i < 220; i++) drive_cycle(bit'($urandom), 0, 0, 0, 1);

    // periodTop change mid-run
    top = 2048;
    repeat (2) run_period(4096, 0, 0, 0, 1, 1, 0);
    top = 1024;
    repeat (2) run_period(2048, 0, 0, 0, 1, 2, 0);
    check_val("pm_after_top_change", 32'(seen_p), 2048);

    // Randomized periods, including short ones and timeouts
    for (int r = 0; r < 30; r++) begin
      top = int'($urandom_range(400, 20));
      len = int'($urandom_range(2 * top + SLACK + 8, 2));
      sw  = int'($urandom_range((len - 1 < 3) ? len - 1 : 3, 1));
      run_period(len, 0, 0, 0, 1, sw, 1);
    end

    // Mid-period reset
    top = 2048;
    run_period(4096, 1500, 700, 300, 0, 1, 0);
    run_period(1000, 0, 0, 0, 1, 1, 0);
    #2;
    rstb = 1'b0; rst_drv = 1'b0;
    #1;
    model_reset();
    check_val("mid_rst_dutyA", 32'(dutyA), 0);
    check_val("mid_rst_pm", 32'(periodMeas), 0);
    check_val("mid_rst_locked", 32'(locked), 0);
    check_val("mid_rst_err", 32'(timeoutErr), 0);
    repeat (3) drive_cycle(0, 0, 0, 0, 0);
    rst_drv = 1'b1;
    top = 150;
    v0 = seen_valid;
    run_period(300, 0, 0, 0, 1, 1, 0);
    check_val("no_valid_first_edge", seen_valid, v0);
    run_period(300, 0, 0, 0, 1, 1, 0);
    check_val("valid_second_edge", seen_valid, v0 + 1);
    check_val("post_rst_pm", 32'(seen_p), 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/svm_pwm_capture.md
# svm_pwm_capture

Measures the three-phase PWM outputs of the space-vector modulator over each carrier period and reports per-phase high-time counts, the measured period length and a lock/timeout status. It sits downstream of `svm`, taking `pwmA/B/C` and the modulator's `halt` strobe as the period marker. It closes the loop for self-check, duty readback and fault detection.

## Interface
- `D_WIDTH`, 16, width of `periodTop`; counts are `D_WIDTH+1` bits.
- `SLACK`, 4, extra cycles beyond the nominal period before timeout.
- `clk`  in  1  system clock, rising edge.
- `rstb`  in  1  reset, asynchronous, active-low.
- `pwmA`, `pwmB`, `pwmC`  in  1 each  phase PWM from modulator.
- `periodSync`  in  1  period marker (modulator `halt`); its rising edge delimits periods.
- `periodTop`  in  D_WIDTH  carrier half-period; nominal period = 2·periodTop cycles.
- `errClr`  in  1  clears `timeoutErr`.
- `dutyA`, `dutyB`, `dutyC`  out  D_WIDTH+1 each  high-cycle count of last complete period.
- `periodMeas`  out  D_WIDTH+1  cycle count of last complete period.
- `dutyValid`  out  1  one-cycle pulse when the count outputs update.
- `locked`  out  1  high while measuring between valid sync edges.
- `timeoutErr`  out  1  sticky; set on sync loss.

## Operation
- Sync edge: `syncEdge = periodSync & ~syncQ`; `syncQ` is registered.
- FSM has two states, IDLE and MEAS.
  - IDLE: counters held at 0, `locked`=0. On `syncEdge`, go to MEAS and load counters from the current cycle. The first partial period is discarded and no `dutyValid` is issued.
  - MEAS, on `syncEdge`:
    - Latch `cntA/B/C` into `dutyA/B/C` and `cntP` into `periodMeas`, then pulse `dutyValid`.
    - Reload: `cntP`=1 and `cntX`=`pwmX` (the current cycle belongs to the new period).
  - MEAS, otherwise: `cntP`+=1 and `cntX`+=`pwmX`. All counters saturate at all-ones.
  - MEAS timeout: when `cntP` ≥ 2·periodTop + SLACK without a sync edge, go to IDLE, set `timeoutErr`, and leave the outputs unchanged.
- Simultaneous sync edge and timeout threshold: the sync edge wins. The counts are latched and no error is raised.
- `errClr` clears `timeoutErr`. If `errClr` and a timeout occur in the same cycle, set wins.
- Arithmetic width rules:
  - Threshold is computed in D_WIDTH+2 bits, so no overflow.
  - `periodTop`=0 gives a threshold of SLACK.
  - `periodTop` is sampled every cycle and need not be stable.
- Reset state, all registers: IDLE, `syncQ`=0, counters=0, `duty*`=0, `periodMeas`=0, `dutyValid`=0, `locked`=0, `timeoutErr`=0.
- Reset mid-period: counts are discarded. A fresh first sync edge is needed before the next `dutyValid`.

## Timing
- `syncEdge` is sampled at edge N. The counts and the `dutyValid` pulse are visible after edge N+1, i.e. 1-cycle latency.
- `dutyValid` is high for exactly one cycle per accepted period.
- `locked` rises the cycle after the first sync edge and falls the cycle after a timeout.
- `periodSync` held high generates one edge only. A period shorter than 2 cycles is still counted as measured, with no error.
- All outputs are registered.

## Configuration
- `SVM_CAPTURE_SYNC_EN` defined:
  - `pwmA/B/C` and `periodSync` each pass through a 2-flop synchronizer, reset to 0, for external pin capture.
  - End-to-end latency from a pin to `dutyValid` becomes 3 cycles.
  - Measured values are unchanged in steady state.
- Macro undefined: inputs are used directly, suitable for the same-clock on-chip loopback.

## Structure
- Shared `svm_pkg` holds:
  - the default `D_WIDTH`;
  - a `capture_state_t` enum with values IDLE and MEAS;
  - a saturating-increment function used by all counters.
- Sub-module `svm_high_counter`: one saturating counter with load/increment/enable inputs. It is instantiated four times (A, B, C, period).

## Test plan
- **Reset and first period.** Stimulus: `rstb` pulse, `periodTop`=2048, sync edge every 4096 cycles. Response: all outputs 0 through reset and the first partial period; first `dutyValid` at the second sync edge + 1, with `periodMeas`=4096.
- **Duty readback.** Stimulus: `pwmA`, `pwmB`, `pwmC` high for 2048, 1024 and 0 cycles per period. Response: `dutyA`=2048, `dutyB`=1024, `dutyC`=0 every period.
- **Full duty.** Stimulus: `pwmA` held high. Response: `dutyA`=4096, equal to `periodMeas`.
- **Sync loss.** Stimulus: stop the sync edges with `periodTop`=2048. Response: `timeoutErr` and ~`locked` at cycle 4100 after the last edge; the outputs keep their last values; `errClr` clears the flag.
- **Boundary timing.** Stimulus: a sync edge arriving exactly at the threshold cycle. Response: the period is accepted with no error. Separately, `periodTop` changed from 2048 to 1024 mid-run gives `periodMeas` tracking the actual edges.
- **Mid-period reset.** Stimulus: assert `rstb` mid-period. Response: immediate zeros, and no `dutyValid` until two sync edges after reset release.
